// File: rtl/program_loader.sv
// Framed byte-stream loader for instruction memory: assembles 9-bit instructions from {LO, HI}
// byte pairs, writes them from address 0 upward and releases core reset once the checksum matches.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LO,
    S_HI,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [7:0] remaining_q, remaining_d;
  logic [7:0] lo_q,        lo_d;
  logic [7:0] acc_q,       acc_d;
  logic [7:0] idx_q,       idx_d;

  logic               in_ready_q,   in_ready_d;
  logic               im_we_q,      im_we_d;
  logic [ADDR_W-1:0]  im_addr_q,    im_addr_d;
  logic [INSTR_W-1:0] im_wdata_q,   im_wdata_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               error_q,      error_d;

  logic xfer;

  // Only bit 0 of a HI byte carries information; anything above it marks a corrupt frame.
  function automatic logic hi_byte_ok(input logic [7:0] b);
    return (b[7:1] == 7'd0);
  endfunction

  function automatic logic [INSTR_W-1:0] pack_instr(input logic hi0, input logic [7:0] lo);
    return {hi0, lo};
  endfunction

  // in_ready is high exactly in the byte-consuming states, so it doubles as the handshake gate.
  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    lo_d         = lo_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    in_ready_d   = in_ready_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_HDR;
          in_ready_d   = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          core_reset_d = 1'b1;
          idx_d        = 8'd0;
          acc_d        = 8'd0;
        end
      end

      S_HDR: begin
        if (xfer) begin
          remaining_d = in_data;
          acc_d       = acc_q ^ in_data;
          state_d     = S_LO;
        end
      end

      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          acc_d   = acc_q ^ in_data;
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (xfer) begin
          if (!hi_byte_ok(in_data)) begin
            state_d    = S_ERR;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            error_d    = 1'b1;
          end else begin
            acc_d      = acc_q ^ in_data;
            im_we_d    = 1'b1;
            im_addr_d  = idx_q;
            im_wdata_d = pack_instr(in_data[0], lo_q);
            // idx wraps harmlessly after the 256th instruction.
            idx_d      = idx_q + 8'd1;
            if (remaining_q == 8'd0) begin
              state_d = S_CSUM;
            end else begin
              remaining_d = remaining_q - 8'd1;
              state_d     = S_LO;
            end
          end
        end
      end

      S_CSUM: begin
        if (xfer) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (in_data == acc_q) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset returns every register to its idle value; instruction memory contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= 8'd0;
      lo_q         <= 8'd0;
      acc_q        <= 8'd0;
      idx_q        <= 8'd0;
      in_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      lo_q         <= lo_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      in_ready_q   <= in_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames, each checked against a frame-level
// model that derives expected writes and the load outcome straight from the frame bytes.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       im_we;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic       core_reset;
  logic       busy;
  logic       done;
  logic       error;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame_q[$];
  logic [16:0] exp_w[$];

  program_loader #(.ADDR_W(8), .INSTR_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock; outputs are sampled on the falling edge, where inputs are also driven.
  task automatic tick();
    logic [16:0] w;
    @(posedge clk);
    @(negedge clk);
    if (im_we === 1'b1) begin
      check("we_expected", 32'(exp_w.size() > 0), 32'd1);
      if (exp_w.size() > 0) begin
        w = exp_w.pop_front();
        check("im_addr", 32'(im_addr), 32'(w[16:9]));
        check("im_wdata", 32'(im_wdata), 32'(w[8:0]));
      end
    end
  endtask

  // Frame-level reference: N = CNT+1 pairs, HI above 1 aborts the load, checksum is XOR of all bytes.
  task automatic model(output bit ok, output int consumed);
    int n;
    logic [7:0] x;
    logic [7:0] lo;
    logic [7:0] hi;
    exp_w.delete();
    n = int'(frame_q[0]) + 1;
    x = frame_q[0];
    for (int k = 0; k < n; k++) begin
      lo = frame_q[1 + 2*k];
      hi = frame_q[2 + 2*k];
      if (hi > 8'd1) begin
        ok = 1'b0;
        consumed = 3 + 2*k;
        return;
      end
      exp_w.push_back({8'(k % 256), hi[0], lo});
      x = x ^ lo ^ hi;
    end
    consumed = 2*n + 2;
    ok = (frame_q[2*n + 1] == x);
  endtask

  task automatic gen_frame(input int n, input int corrupt);
    logic [7:0] x;
    logic [7:0] b;
    int bad_k;
    frame_q.delete();
    bad_k = $urandom_range(0, n - 1);
    b = 8'(n - 1);
    frame_q.push_back(b);
    x = b;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x = x ^ b;
      b = 8'($urandom_range(0, 1));
      if (corrupt == 1 && k == bad_k) b = b | (8'h02 << $urandom_range(0, 6));
      frame_q.push_back(b);
      x = x ^ b;
    end
    frame_q.push_back((corrupt == 2) ? (x ^ 8'h5A) : x);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_core_reset", 32'(core_reset), 32'd1);
  endtask

  // mode 0: random stalls, 1: valid toggles every cycle, 2: valid held high.
  task automatic send(input int nbytes, input int mode, input bit poke_start);
    int i = 0;
    int cyc = 0;
    bit v;
    bit tog = 1'b1;
    bit acc;
    while (i < nbytes && cyc < 4000) begin
      case (mode)
        1:       v = tog;
        2:       v = 1'b1;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      tog = ~tog;
      in_valid = v;
      in_data  = v ? frame_q[i] : 8'($urandom);
      start    = poke_start && ($urandom_range(0, 15) == 0);
      acc      = v && (in_ready === 1'b1);
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("bytes_accepted", 32'(i), 32'(nbytes));
  endtask

  task automatic end_checks(input bit ok);
    check("end_in_ready", 32'(in_ready), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_core_reset", 32'(core_reset), 32'(!ok));
    check("writes_left", 32'(exp_w.size()), 32'd0);
  endtask

  task automatic run_load(input int mode, input bit poke_start);
    bit ok;
    int consumed;
    model(ok, consumed);
    do_start();
    send(consumed, mode, poke_start);
    end_checks(ok);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    bit ok;
    int consumed;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    tick();
    tick();
    check_reset_values();
    reset = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Two instructions, correct checksum.
    frame_q = '{8'h01, 8'h05, 8'h00, 8'hFF, 8'h01, 8'hFA};
    model(ok, consumed);
    check("model_dir_ok", 32'(ok), 32'd1);
    check("model_dir_w0", 32'(exp_w[0]), 32'h00005);
    check("model_dir_w1", 32'(exp_w[1]), 32'h003FF);
    run_load(2, 1'b0);

    // Same frame with a bad checksum: writes still happen, load fails.
    frame_q = '{8'h01, 8'h05, 8'h00, 8'hFF, 8'h01, 8'h00};
    run_load(0, 1'b0);

    // HI byte with bit 1 set aborts before any write.
    frame_q = '{8'h00, 8'h12, 8'h02};
    run_load(2, 1'b0);

    // Valid toggling every cycle through a three-instruction frame.
    gen_frame(3, 0);
    run_load(1, 1'b0);

    // Reset after the first LO byte, then a clean load.
    gen_frame(2, 0);
    model(ok, consumed);
    do_start();
    send(2, 2, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    exp_w.delete();
    tick();
    gen_frame(2, 0);
    run_load(0, 1'b0);

    // Maximum frame: 256 instructions covering every address once.
    gen_frame(256, 0);
    run_load(0, 1'b0);

    // Random frames with stray start pulses while busy.
    for (int t = 0; t < 12; t++) begin
      gen_frame($urandom_range(1, 8), $urandom_range(0, 2));
      run_load(0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
